// File: rtl/switch_alloc_pkg.sv
// Shared router definitions: port codes, widths and output lock states.
// Used by the switch allocator and its round-robin arbiter.
package switch_alloc_pkg;

  localparam int NPORT = 5;
  localparam int PW    = 3;

  typedef logic [PW-1:0] port_t;

  localparam port_t PORT_R  = 3'd0;
  localparam port_t PORT_L  = 3'd1;
  localparam port_t PORT_U  = 3'd2;
  localparam port_t PORT_D  = 3'd3;
  localparam port_t PORT_EJ = 3'd4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  function automatic port_t next_port(input port_t p);
    return (p == PORT_EJ) ? PORT_R : p + 3'd1;
  endfunction

  function automatic logic legal_port(input port_t p);
    return p inside {PORT_R, PORT_L, PORT_U, PORT_D, PORT_EJ};
  endfunction

endpackage

// File: rtl/switch_allocator_rr_arb5.sv
// Five-request round-robin arbiter: scans from ptr upward, mod 5.
// Produces a one-hot grant, the winning index and an any-request flag.
module rr_arb5
  import switch_alloc_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  port_t            ptr,
  output logic [NPORT-1:0] gnt,
  output port_t            idx,
  output logic             any
);

  port_t cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = ptr;
    for (int k = 0; k < NPORT; k++) begin
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
      cand = next_port(cand);
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: per-output round-robin with packet locking.
// Optional lock watchdog compiled in with SWITCH_ALLOC_WATCHDOG_EN.
module switch_allocator
  import switch_alloc_pkg::*;
#(
  parameter int WD_CYCLES = 64,
  parameter int WD_W      = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NPORT-1:0]    in_valid,
  input  logic [NPORT*PW-1:0] in_dest,
  input  logic [NPORT-1:0]    in_tail,
  input  logic [NPORT-1:0]    out_ready,
  output logic [NPORT-1:0]    in_grant,
  output logic [NPORT-1:0]    out_valid,
  output logic [NPORT*PW-1:0] out_sel,
  output logic [NPORT-1:0]    out_lock,
  output logic                err,
  output logic                wd_flag
);

  if (2**WD_W <= WD_CYCLES) begin : g_wd_check
    $error("WD_W too narrow for WD_CYCLES");
  end

  port_t            dest    [NPORT];
  port_t            win     [NPORT];
  port_t            owner_q [NPORT];
  port_t            ptr_q   [NPORT];
  state_t           state_q [NPORT];
  logic [NPORT-1:0] req     [NPORT];
  logic [NPORT-1:0] arb_gnt [NPORT];
  port_t            arb_idx [NPORT];
  logic             arb_any [NPORT];
  logic [NPORT-1:0] sel_vec [NPORT];
  logic [NPORT-1:0] xfer;
  logic             err_now;
  logic             err_q;

  always_comb begin
    for (int i = 0; i < NPORT; i++)
      dest[i] = in_dest[PW*i +: PW];
    for (int o = 0; o < NPORT; o++)
      for (int i = 0; i < NPORT; i++)
        req[o][i] = in_valid[i] && (dest[i] == port_t'(o));
  end

  for (genvar o = 0; o < NPORT; o++) begin : g_arb
    rr_arb5 u_arb (
      .req (req[o]),
      .ptr (ptr_q[o]),
      .gnt (arb_gnt[o]),
      .idx (arb_idx[o]),
      .any (arb_any[o])
    );
  end

  always_comb begin
    in_grant  = '0;
    out_valid = '0;
    out_sel   = '0;
    out_lock  = '0;
    xfer      = '0;
    err_now   = 1'b0;
    for (int i = 0; i < NPORT; i++)
      if (in_valid[i] && !legal_port(dest[i]))
        err_now = 1'b1;
    for (int o = 0; o < NPORT; o++) begin
      if (state_q[o] == ST_LOCKED) begin
        win[o]     = owner_q[o];
        sel_vec[o] = 5'b00001 << owner_q[o];
        xfer[o]    = !reset && in_valid[owner_q[o]] &&
                     dest[owner_q[o]] == port_t'(o) &&
                     out_ready[o];
        // owner wandered off to another output mid-packet
        if (in_valid[owner_q[o]] &&
            dest[owner_q[o]] != port_t'(o))
          err_now = 1'b1;
        out_lock[o] = !reset;
        if (!reset)
          out_sel[PW*o +: PW] = owner_q[o];
      end else begin
        win[o]     = arb_idx[o];
        sel_vec[o] = arb_gnt[o];
        xfer[o]    = !reset && arb_any[o] && out_ready[o];
      end
      if (xfer[o]) begin
        out_valid[o]        = 1'b1;
        out_sel[PW*o +: PW] = win[o];
        in_grant            = in_grant | sel_vec[o];
      end
    end
  end

`ifdef SWITCH_ALLOC_WATCHDOG_EN
  logic [WD_W-1:0]  wd_cnt_q [NPORT];
  logic [NPORT-1:0] wd_hit;
  logic             wd_q;

  // hit on the WD_CYCLES-th consecutive stalled cycle of a lock
  always_comb begin
    for (int o = 0; o < NPORT; o++)
      wd_hit[o] = state_q[o] == ST_LOCKED && !xfer[o] &&
                  wd_cnt_q[o] == WD_W'(WD_CYCLES - 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q <= 1'b0;
      for (int o = 0; o < NPORT; o++)
        wd_cnt_q[o] <= '0;
    end else begin
      if (|wd_hit)
        wd_q <= 1'b1;
      for (int o = 0; o < NPORT; o++)
        if (state_q[o] == ST_IDLE || xfer[o] || wd_hit[o])
          wd_cnt_q[o] <= '0;
        else
          wd_cnt_q[o] <= wd_cnt_q[o] + 1'b1;
    end
  end

  assign wd_flag = wd_q && !reset;
`else
  assign wd_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
      for (int o = 0; o < NPORT; o++) begin
        state_q[o] <= ST_IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      err_q <= err_q | err_now;
      for (int o = 0; o < NPORT; o++) begin
        if (xfer[o]) begin
          if (in_tail[win[o]]) begin
            state_q[o] <= ST_IDLE;
            ptr_q[o]   <= next_port(win[o]);
          end else begin
            state_q[o] <= ST_LOCKED;
            owner_q[o] <= win[o];
          end
        end
`ifdef SWITCH_ALLOC_WATCHDOG_EN
        else if (wd_hit[o]) begin
          state_q[o] <= ST_IDLE;
          ptr_q[o]   <= next_port(owner_q[o]);
        end
`endif
      end
    end
  end

  assign err = err_q && !reset;

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed scenarios plus random traffic
// checked against a packet-level model of the allocation rules.
module tb_switch_allocator;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  in_valid, in_tail, out_ready;
  logic [14:0] in_dest;
  logic [4:0]  in_grant, out_valid, out_lock;
  logic [14:0] out_sel;
  logic        err, wd_flag;

  int checks = 0;
  int errors = 0;

  int   m_lock [5];
  int   m_ptr  [5];
  bit   m_err;
  int   rd     [5];
  int   e_win  [5];
  logic [4:0]  e_grant, e_valid, e_lock;
  logic [14:0] e_sel;
  bit   e_errnow;

  always #5 clk = ~clk;

  switch_allocator dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_dest   (in_dest),
    .in_tail   (in_tail),
    .out_ready (out_ready),
    .in_grant  (in_grant),
    .out_valid (out_valid),
    .out_sel   (out_sel),
    .out_lock  (out_lock),
    .err       (err),
    .wd_flag   (wd_flag)
  );

  function automatic logic [14:0] pack5(input int a, b, c, d, e);
    return {3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 5'b11111;
    in_dest = pack5(4, 4, 4, 4, 4);
    in_tail = 5'b11111;
    out_ready = 5'b11111;
    #2;
    checks++;
    if ({in_grant, out_valid} !== 10'b0) begin
      errors++;
      $display("FAIL reset_grant: got %b want 0", {in_grant, out_valid});
    end
    checks++;
    if ({out_lock, out_sel, err, wd_flag} !== 22'b0) begin
      errors++;
      $display("FAIL reset_state: got %b want 0",
               {out_lock, out_sel, err, wd_flag});
    end
    next_cycle();
    reset = 1'b0;
    in_valid = '0;
  endtask

  task automatic test_eject_rr();
    logic [4:0] vt [4] = '{5'b00111, 5'b00110, 5'b00100, 5'b01001};
    logic [4:0] gt [4] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000};
    logic [2:0] st [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    for (int c = 0; c < 4; c++) begin
      in_valid = vt[c];
      in_dest = pack5(4, 4, 4, 4, 4);
      in_tail = 5'b11111;
      out_ready = 5'b11111;
      #2;
      checks++;
      if (in_grant !== gt[c]) begin
        errors++;
        $display("FAIL eject_grant c%0d: got %b want %b", c, in_grant, gt[c]);
      end
      checks++;
      if (out_valid !== 5'b10000 || out_sel[14:12] !== st[c]) begin
        errors++;
        $display("FAIL eject_sel c%0d: got %b/%0d want 10000/%0d",
                 c, out_valid, out_sel[14:12], st[c]);
      end
      next_cycle();
    end
    in_valid = '0;
  endtask

  task automatic test_lock();
    logic [4:0] eg;
    logic       el;
    logic [2:0] es;
    in_valid = 5'b00100;
    in_dest = pack5(0, 0, 0, 0, 0);
    in_tail = 5'b11111;
    out_ready = 5'b11111;
    #2;
    checks++;
    if (in_grant !== 5'b00100) begin
      errors++;
      $display("FAIL lock_pre: got %b want 00100", in_grant);
    end
    next_cycle();
    for (int c = 0; c < 5; c++) begin
      in_valid = (c < 4) ? 5'b01010 : 5'b00010;
      in_tail = (c == 3) ? 5'b01010 : 5'b00010;
      eg = (c < 4) ? 5'b01000 : 5'b00010;
      el = (c >= 1 && c <= 3);
      es = (c < 4) ? 3'd3 : 3'd1;
      #2;
      checks++;
      if (in_grant !== eg || out_sel[2:0] !== es) begin
        errors++;
        $display("FAIL lock_grant c%0d: got %b/%0d want %b/%0d",
                 c, in_grant, out_sel[2:0], eg, es);
      end
      checks++;
      if (out_lock[0] !== el) begin
        errors++;
        $display("FAIL lock_flag c%0d: got %b want %b", c, out_lock[0], el);
      end
      next_cycle();
    end
    in_valid = '0;
  endtask

  task automatic test_ready_stall();
    logic rt [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    in_valid = 5'b00001;
    in_dest = pack5(0, 0, 0, 0, 0);
    in_tail = 5'b00000;
    out_ready = 5'b11111;
    #2;
    checks++;
    if (in_grant !== 5'b00001) begin
      errors++;
      $display("FAIL stall_head: got %b want 00001", in_grant);
    end
    next_cycle();
    for (int c = 0; c < 4; c++) begin
      in_valid = 5'b10001;
      out_ready = {4'b1111, rt[c]};
      #2;
      checks++;
      if (in_grant !== (rt[c] ? 5'b00001 : 5'b00000)) begin
        errors++;
        $display("FAIL stall_grant c%0d: got %b want %b",
                 c, in_grant, rt[c] ? 5'b00001 : 5'b00000);
      end
      checks++;
      if (out_lock[0] !== 1'b1 || err !== 1'b0) begin
        errors++;
        $display("FAIL stall_lock c%0d: got lock %b err %b want 1 0",
                 c, out_lock[0], err);
      end
      next_cycle();
    end
    in_valid = 5'b10001;
    in_tail = 5'b00001;
    out_ready = 5'b11111;
    #2;
    checks++;
    if (in_grant !== 5'b00001) begin
      errors++;
      $display("FAIL stall_tail: got %b want 00001", in_grant);
    end
    next_cycle();
    in_valid = 5'b10000;
    in_tail = 5'b10000;
    #2;
    checks++;
    if (in_grant !== 5'b10000 || out_lock[0] !== 1'b0) begin
      errors++;
      $display("FAIL stall_after: got %b lock %b want 10000 0",
               in_grant, out_lock[0]);
    end
    next_cycle();
    in_valid = '0;
  endtask

  task automatic test_illegal_dest();
    in_valid = 5'b00100;
    in_dest = pack5(0, 0, 6, 0, 0);
    in_tail = 5'b11111;
    out_ready = 5'b11111;
    #2;
    checks++;
    if (in_grant !== 5'b0 || out_valid !== 5'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_now: got %b %b err %b want 0 0 0",
               in_grant, out_valid, err);
    end
    next_cycle();
    in_valid = '0;
    for (int c = 0; c < 2; c++) begin
      #2;
      checks++;
      if (err !== 1'b1) begin
        errors++;
        $display("FAIL illegal_sticky c%0d: got %b want 1", c, err);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_packet();
    in_valid = 5'b00010;
    in_dest = pack5(0, 2, 0, 0, 0);
    in_tail = 5'b00000;
    out_ready = 5'b11111;
    #2;
    checks++;
    if (in_grant !== 5'b00010) begin
      errors++;
      $display("FAIL mid_head: got %b want 00010", in_grant);
    end
    next_cycle();
    #2;
    checks++;
    if (out_lock !== 5'b00100 || in_grant !== 5'b00010) begin
      errors++;
      $display("FAIL mid_body: got lock %b grant %b want 00100 00010",
               out_lock, in_grant);
    end
    next_cycle();
    reset = 1'b1;
    #2;
    checks++;
    if (in_grant !== 5'b0 || out_lock !== 5'b0) begin
      errors++;
      $display("FAIL mid_reset: got grant %b lock %b want 0 0",
               in_grant, out_lock);
    end
    next_cycle();
    reset = 1'b0;
    in_valid = 5'b11001;
    in_dest = pack5(4, 0, 0, 2, 4);
    in_tail = 5'b10001;
    #2;
    checks++;
    if (out_lock !== 5'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL mid_after_state: got lock %b err %b want 0 0",
               out_lock, err);
    end
    checks++;
    if (in_grant !== 5'b01001 || out_sel[14:12] !== 3'd0 ||
        out_sel[8:6] !== 3'd3) begin
      errors++;
      $display("FAIL mid_after_grant: got %b sel4 %0d sel2 %0d want 01001 0 3",
               in_grant, out_sel[14:12], out_sel[8:6]);
    end
    next_cycle();
    in_valid = '0;
  endtask

  task automatic model_eval();
    int w;
    e_grant = '0;
    e_valid = '0;
    e_lock = '0;
    e_sel = '0;
    e_errnow = 1'b0;
    for (int i = 0; i < 5; i++)
      if (in_valid[i] && rd[i] > 4) e_errnow = 1'b1;
    for (int o = 0; o < 5; o++) begin
      w = -1;
      e_win[o] = 0;
      if (m_lock[o] >= 0) begin
        e_lock[o] = 1'b1;
        e_sel[3*o +: 3] = 3'(m_lock[o]);
        if (in_valid[m_lock[o]] && rd[m_lock[o]] != o) e_errnow = 1'b1;
        if (in_valid[m_lock[o]] && rd[m_lock[o]] == o) w = m_lock[o];
      end else begin
        for (int s = 0; s < 5; s++) begin
          int i;
          i = (m_ptr[o] + s) % 5;
          if (w < 0 && in_valid[i] && rd[i] == o) w = i;
        end
      end
      if (w >= 0 && out_ready[o]) begin
        e_valid[o] = 1'b1;
        e_grant[w] = 1'b1;
        e_sel[3*o +: 3] = 3'(w);
        e_win[o] = w;
      end
    end
  endtask

  task automatic model_commit();
    for (int o = 0; o < 5; o++) begin
      if (e_valid[o]) begin
        if (in_tail[e_win[o]]) begin
          m_lock[o] = -1;
          m_ptr[o] = (e_win[o] + 1) % 5;
        end else begin
          m_lock[o] = e_win[o];
        end
      end
    end
    if (e_errnow) m_err = 1'b1;
  endtask

  task automatic test_random();
    reset = 1'b1;
    in_valid = '0;
    next_cycle();
    reset = 1'b0;
    m_err = 1'b0;
    for (int o = 0; o < 5; o++) begin
      m_lock[o] = -1;
      m_ptr[o] = 0;
      rd[o] = int'($urandom % 5);
    end
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 5; i++) begin
        in_valid[i] = ($urandom % 10) < 7;
        in_tail[i] = ($urandom % 3) == 0;
        out_ready[i] = ($urandom % 4) != 0;
      end
      in_dest = pack5(rd[0], rd[1], rd[2], rd[3], rd[4]);
      #2;
      model_eval();
      checks++;
      if (in_grant !== e_grant) begin
        errors++;
        $display("FAIL rand_grant n%0d: got %b want %b", n, in_grant, e_grant);
      end
      checks++;
      if (out_valid !== e_valid) begin
        errors++;
        $display("FAIL rand_valid n%0d: got %b want %b", n, out_valid, e_valid);
      end
      checks++;
      if (out_sel !== e_sel) begin
        errors++;
        $display("FAIL rand_sel n%0d: got %h want %h", n, out_sel, e_sel);
      end
      checks++;
      if (out_lock !== e_lock) begin
        errors++;
        $display("FAIL rand_lock n%0d: got %b want %b", n, out_lock, e_lock);
      end
      checks++;
      if (err !== m_err) begin
        errors++;
        $display("FAIL rand_err n%0d: got %b want %b", n, err, m_err);
      end
      model_commit();
      for (int i = 0; i < 5; i++) begin
        if (rd[i] > 4)
          rd[i] = int'($urandom % 5);
        else if (e_grant[i] && in_tail[i])
          rd[i] = ($urandom % 150 == 0) ? 5 + int'($urandom % 3)
                                        : int'($urandom % 5);
      end
      next_cycle();
    end
    in_valid = '0;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = '0;
    in_dest = '0;
    in_tail = '0;
    out_ready = '0;
    next_cycle();
    test_reset();
    test_eject_rr();
    test_lock();
    test_ready_stall();
    test_illegal_dest();
    test_reset_mid_packet();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
